serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor built around the team's 1-bit full-subtractor stage (difference = a^b^bin, borrow = (~(a^b)&bin)|(~a&b)).
- Loads two WIDTH-bit operands and feeds the full subtractor one bit per clock, LSB first.
- Holds the borrow between cycles in a flip-flop, collects the difference bits in a shift register, and presents the result with a one-cycle done pulse.
- Sits upstream of the full subtractor as its sequencer and operand feeder.
- Consumes the full subtractor's difference and borrow outputs every cycle.

Parameters:
WIDTH  8  operand/result width in bits; legal range 2..32

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous, active-low reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  minuend; captured on accepted start
b      input   WIDTH  subtrahend; captured on accepted start
busy   output  1      high while in RUN
done   output  1      one-cycle pulse; result valid
diff   output  WIDTH  a - b mod 2^WIDTH; held until next completion
bout   output  1      final borrow: 1 if and only if a < b (unsigned)

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, any time, including mid-RUN):
  - state=IDLE.
  - busy=0, done=0, diff=0, bout=0.
  - Operand shift registers, result shift register, borrow flip-flop and bit counter all cleared.
  - Operation in progress is abandoned; no done pulse.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1. Lasts exactly one cycle.
- Transitions:
  - IDLE -> RUN on an edge with start=1. At that edge: load a and b into the operand shift registers, borrow<=0, cnt<=0.
  - RUN, each edge:
    - Drive A_sr[0], B_sr[0] and the borrow flip-flop into the full subtractor.
    - Shift the difference bit into the result shift register MSB, shifting right.
    - Shift A_sr and B_sr right by one.
    - borrow <= full-subtractor borrow output; cnt <= cnt+1.
  - RUN -> DONE on the edge where cnt==WIDTH-1. At that same edge: diff <= final result shift-register value (including the bit just produced), bout <= final borrow output.
  - DONE -> IDLE unconditionally on the next edge.
- Latency: start accepted at edge k; done=1 in the cycle after edge k+WIDTH; IDLE again after edge k+WIDTH+1.
- Back-to-back throughput: one operation per WIDTH+2 cycles.
- Start handling:
  - start in RUN or DONE is ignored; it is not queued.
  - start held high continuously restarts from IDLE each time IDLE is reached.
- Operand timing: a and b are sampled only at the accepting edge. Changes during RUN have no effect.
- Output holding: diff and bout update only on entry to DONE. They hold the previous result through IDLE and RUN, and are 0 after reset.
- Counter: $clog2(WIDTH) bits; never exceeds WIDTH-1.
- Arithmetic: unsigned modular subtraction. bout is the borrow out of bit WIDTH-1.
- Equal operands give diff=0, bout=0.

Test Plan:
- Default WIDTH=8; start pulsed for one cycle unless noted.
- a=0x5A, b=0x3C -> after 8 RUN cycles done=1 for one cycle, diff=0x1E, bout=0. busy high exactly 8 cycles.
- a=0x3C, b=0x5A -> diff=0xE2, bout=1.
- a=0x00, b=0x01 -> diff=0xFF, bout=1 (borrow ripples through all bits). a=0x80, b=0x80 -> diff=0x00, bout=0.
- Start a=0x10, b=0x01. Pulse start with a=0xFF, b=0x00 on RUN cycle 3 and again in the DONE cycle -> only diff=0x0F, bout=0 produced. No second done without a new start in IDLE.
- Start a=0x5A, b=0x3C. Assert rst_n=0 asynchronously mid-cycle during RUN cycle 4 -> busy, done, diff and bout go to 0 immediately with no clock. After release, a new op a=0x09, b=0x03 -> diff=0x06, bout=0 with correct latency.
- Random sweep of 1000 operand pairs with start held high -> every done matches (a-b) mod 256 and bout==(a<b). done pulses are spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives requests; the slave (the subtractor) returns results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor step per clock,
// LSB first, with a borrow flop and a right-shifting result register.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  io
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fs_a, fs_b, fs_bin;
  logic             fs_diff, fs_bout;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor stage fed from the operand LSBs.
  assign fs_a    = a_sr_q[0];
  assign fs_b    = b_sr_q[0];
  assign fs_bin  = borrow_q;
  assign fs_diff = fs_a ^ fs_b ^ fs_bin;
  assign fs_bout = (~(fs_a ^ fs_b) & fs_bin)
                 | (~fs_a & fs_b);

  assign res_next = {fs_diff, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d  = RUN;
          a_sr_d   = io.a;
          b_sr_d   = io.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_d    = res_next;
        borrow_d = fs_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = res_next;
          bout_d  = fs_bout;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign io.busy = (state_q == RUN);
  assign io.done = (state_q == DONE);
  assign io.diff = diff_q;
  assign io.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle-level arithmetic model plus
// directed vectors with hand-computed results.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;

  serial_subtractor_if #(.WIDTH(W)) io ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: an accepted op occupies W busy cycles, then one done cycle.
  int         m_left;
  bit         m_done;
  bit [W-1:0] m_a, m_b;
  bit [W-1:0] m_diff;
  bit         m_bout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_diff <= '0;
      m_bout <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_diff <= m_a - m_b;
        m_bout <= (m_a < m_b);
      end
    end else if (io.start) begin
      m_left <= W;
      m_a    <= io.a;
      m_b    <= io.b;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_busy", 32'(io.busy), 32'(m_left > 0));
      chk("cyc_done", 32'(io.done), 32'(m_done));
      chk("cyc_diff", 32'(io.diff), 32'(m_diff));
      chk("cyc_bout", 32'(io.bout), 32'(m_bout));
    end
  end

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] ed,
                        input logic         eb);
    int nb;
    bit seen;
    nb   = 0;
    seen = 1'b0;
    @(posedge clk);
    #1;
    io.start = 1'b1;
    io.a     = a;
    io.b     = b;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (io.done) seen = 1'b1;
      else if (io.busy) nb++;
    end
    chk("op_done_seen", 32'(seen), 32'd1);
    chk("op_busy_len", nb, W);
    chk("op_diff", 32'(io.diff), 32'(ed));
    chk("op_bout", 32'(io.bout), 32'(eb));
    chk("model_diff", 32'(m_diff), 32'(ed));
    chk("model_bout", 32'(m_bout), 32'(eb));
  endtask

  initial begin
    int  ndone;
    int  last;
    bit  seen;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    io.start    = 1'b0;
    io.a        = '0;
    io.b        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_done", 32'(io.done), 32'd0);
    chk("rst_diff", 32'(io.diff), 32'd0);
    chk("rst_bout", 32'(io.bout), 32'd0);
    rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 8'h1E, 1'b0);
    run_op(8'h3C, 8'h5A, 8'hE2, 1'b1);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1);
    run_op(8'h80, 8'h80, 8'h00, 1'b0);

    // Starts during RUN and DONE must be ignored.
    @(posedge clk);
    #1;
    io.start = 1'b1;
    io.a     = 8'h10;
    io.b     = 8'h01;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    io.start = 1'b1;
    io.a     = 8'hFF;
    io.b     = 8'h00;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (io.done) seen = 1'b1;
    end
    chk("ign_done_seen", 32'(seen), 32'd1);
    chk("ign_diff", 32'(io.diff), 32'h0F);
    chk("ign_bout", 32'(io.bout), 32'd0);
    io.start = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    ndone = 0;
    repeat (14) begin
      @(negedge clk);
      if (io.done) ndone++;
    end
    chk("ign_no_second", ndone, 0);

    // Asynchronous reset during RUN cycle 4.
    @(posedge clk);
    #1;
    io.start = 1'b1;
    io.a     = 8'h5A;
    io.b     = 8'h3C;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(io.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(io.busy), 32'd0);
    chk("arst_done", 32'(io.done), 32'd0);
    chk("arst_diff", 32'(io.diff), 32'd0);
    chk("arst_bout", 32'(io.bout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(8'h09, 8'h03, 8'h06, 1'b0);

    // Sweep with start held high; new operands loaded during DONE.
    @(posedge clk);
    #1;
    io.a     = 8'($urandom);
    io.b     = 8'($urandom);
    io.start = 1'b1;
    ndone = 0;
    last  = -1;
    for (int i = 0; i < 11000 && ndone < 1000; i++) begin
      @(negedge clk);
      if (io.done) begin
        if (last >= 0) chk("sweep_gap", cyc - last, W + 2);
        last = cyc;
        ndone++;
        io.a = 8'($urandom);
        io.b = 8'($urandom);
      end
    end
    chk("sweep_count", ndone, 1000);
    io.start = 1'b0;
    repeat (12) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
